// File: rtl/paralelo_serial_pkg.sv
// Shared link characters, byte width and transmitter state type; also used by the receiver side for comma detection.
package paralelo_serial_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] COMMA_CHAR = 8'hBC;
  localparam logic [BYTE_W-1:0] IDLE_CHAR  = 8'h7C;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } tx_state_t;

endpackage

// File: rtl/paralelo_serial_tx_shift_reg.sv
// Byte load/shift register, MSB first, with bit_idx counter and load-edge strobe.
// The first edge after reset shifts out the reset byte in place, so that byte lands on the same 8-edge grid as later loads.
module tx_shift_reg
  import paralelo_serial_pkg::*;
#(
  parameter logic [BYTE_W-1:0] RST_BYTE = COMMA_CHAR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] next_byte,
  output logic              load_edge,
  output logic              data_out,
  output logic [2:0]        bit_idx
);

  logic [BYTE_W-1:0] sreg;
  logic              started;

  assign load_edge = started && (bit_idx == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg     <= RST_BYTE;
      started  <= 1'b0;
      data_out <= 1'b0;
      bit_idx  <= 3'd0;
    end else begin
      started <= 1'b1;
      if (load_edge) begin
        data_out <= next_byte[BYTE_W-1];
        sreg     <= {next_byte[BYTE_W-2:0], 1'b0};
        bit_idx  <= 3'd0;
      end else begin
        data_out <= sreg[BYTE_W-1];
        sreg     <= {sreg[BYTE_W-2:0], 1'b0};
        if (started) begin
          bit_idx <= bit_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/paralelo_serial_tx.sv
// Serialiser: SYNC_COUNT commas after reset, then user bytes via ready/valid or IDLE filler, MSB first.
// Optional macro TX_RESYNC_EN adds a resync input that returns the link to SYNC at the next byte boundary.
module paralelo_serial_tx
  import paralelo_serial_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_CHAR,
  parameter logic [BYTE_W-1:0] IDLE       = IDLE_CHAR,
  parameter int                SYNC_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
`ifdef TX_RESYNC_EN
  input  logic              resync,
`endif
  output logic              ready,
  output logic              data_out,
  output logic              active,
  output logic [2:0]        bit_idx
);

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

  tx_state_t         state, state_nxt;
  logic [3:0]        sync_cnt, sync_cnt_nxt;
  logic              pending, pending_nxt;
  logic              ready_nxt;
  logic              load_edge;
  logic              resync_req;
  logic [BYTE_W-1:0] next_byte;

`ifdef TX_RESYNC_EN
  assign resync_req = resync;
`else
  assign resync_req = 1'b0;
`endif

  tx_shift_reg #(
    .RST_BYTE (COMMA)
  ) u_shift (
    .clk       (clk_32f),
    .rst       (reset),
    .next_byte (next_byte),
    .load_edge (load_edge),
    .data_out  (data_out),
    .bit_idx   (bit_idx)
  );

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state    <= SYNC;
      sync_cnt <= 4'd0;
      pending  <= 1'b0;
      ready    <= 1'b0;
    end else begin
      state    <= state_nxt;
      sync_cnt <= sync_cnt_nxt;
      pending  <= pending_nxt;
      ready    <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sync_cnt_nxt = sync_cnt;
    pending_nxt  = pending;
    next_byte    = COMMA;

    if (state == ACTIVE && resync_req) begin
      pending_nxt = 1'b1;
    end

    if (load_edge) begin
      if (state == SYNC) begin
        if (sync_cnt == SYNC_LAST) begin
          state_nxt = ACTIVE;
          next_byte = (valid_in && ready) ? data_in : IDLE;
        end else begin
          sync_cnt_nxt = sync_cnt + 4'd1;
        end
      end else if (pending) begin
        // Current byte has finished; restart alignment with a fresh comma run.
        state_nxt    = SYNC;
        sync_cnt_nxt = 4'd0;
        pending_nxt  = 1'b0;
      end else begin
        next_byte = (valid_in && ready) ? data_in : IDLE;
      end
    end

    // Registered, so it is decided one edge early: high during the LSB cycle before a user-byte load.
    ready_nxt = (bit_idx == 3'd6) &&
                ((state == ACTIVE && !pending_nxt) ||
                 (state == SYNC && sync_cnt == SYNC_LAST));
  end

  assign active = (state == ACTIVE);

endmodule
